sram_bridge: RTL
================

# sram_bridge

Sequenced memory bridge between the LC-3 datapath/ISDU and the board's asynchronous 16-bit SRAM. It consumes the ISDU's `Mem_OE`/`Mem_WE` strobes together with MAR/MDR and runs a fixed-latency SRAM read or write cycle. It returns read data in time for the ISDU's third read-strobe cycle, and optionally decodes the memory-mapped switch/hex I/O word.

## Interface
- `WAIT_CYCLES`, 1: SRAM access cycles before read capture; a write pulse lasts `WAIT_CYCLES+1` cycles. Legal range 1..7.
- `Clk` in 1: system clock; all state changes on the rising edge.
- `Reset_n` in 1: reset, synchronous and active-low.
- `Mem_OE` in 1: read request from the ISDU, active high, level held ≥3 cycles.
- `Mem_WE` in 1: write request from the ISDU, active high.
- `MAR` in 16: access address.
- `MDR` in 16: write data.
- `Switches` in 16: raw board switches.
- `SRAM_DQ_in` in 16: SRAM data bus, input side.
- `Data_to_CPU` out 16: read data to the MDR mux.
- `Mem_Ready` out 1: one-cycle completion pulse.
- `SRAM_ADDR` out 20: `{4'h0, latched MAR}`.
- `SRAM_CE_N`, `SRAM_OE_N`, `SRAM_WE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1: SRAM controls, active low.
- `SRAM_DQ_out` out 16: write data. `SRAM_DQ_oe` out 1: tristate enable, used at the top level.
- `HEX_Data` out 16: hex display register.

## Operation
- Request is `req = Mem_OE | Mem_WE`. A request is accepted only on a rising edge, `req & ~req_q`. When both strobes are high at the edge, the request is a write.
- Accept cycle: latch the address, the write data, the op type and, with `MMIO_EN`, a flag `is_io = (MAR == 16'hFFFF)`.
- A rising edge seen outside IDLE sets `pending` and captures address, data and type at that edge. IDLE serves `pending` on the next cycle. A second edge while `pending` is set is dropped.
- States:
  - IDLE: all SRAM controls high, `SRAM_DQ_oe=0`.
  - RD_ACCESS: lasts `WAIT_CYCLES` cycles. `CE_N=OE_N=UB_N=LB_N=0`.
  - RD_CAP: 1 cycle. Same controls as RD_ACCESS. `rdata <= SRAM_DQ_in`, `Mem_Ready=1`. Goes to IDLE.
  - WR_PULSE: lasts `WAIT_CYCLES+1` cycles. `CE_N=WE_N=UB_N=LB_N=0`, `SRAM_DQ_oe=1`.
  - WR_HOLD: 1 cycle. `WE_N=1`, `CE_N=0`, data still driven, `Mem_Ready=1`. Goes to IDLE.
- `Data_to_CPU`:
  - Equals `SRAM_DQ_in` during RD_ACCESS and RD_CAP.
  - Otherwise equals `rdata`.
- A wait counter (3 bits) is loaded on entry to each timed state. The state exits when the counter reaches zero.
- `SRAM_OE_N` and `SRAM_WE_N` are never low in the same cycle. `SRAM_DQ_oe` is 1 only in WR_PULSE and WR_HOLD.

## Timing
- Reset values:
  - State IDLE; `req_q=0`, `pending=0`.
  - `rdata=0`, `HEX_Data=0`, `Mem_Ready=0`, `SRAM_DQ_oe=0`.
  - All SRAM control lines high, `SRAM_ADDR=0`.
- Reset asserted mid-access aborts the cycle: next edge goes to IDLE and no completion pulse is issued.
- Read with default `WAIT_CYCLES=1` and accept at cycle t:
  - RD_ACCESS at t+1.
  - RD_CAP at t+2, with `Data_to_CPU` valid in that cycle, matching the ISDU's MDR load on its third `Mem_OE` cycle.
  - IDLE at t+3.
- Write with accept at t:
  - WR_PULSE at t+1..t+WAIT_CYCLES+1.
  - WR_HOLD at t+WAIT_CYCLES+2.
  - IDLE one cycle later, before the ISDU's next fetch strobe.
- A strobe still held high after completion does not retrigger; a new rising edge is required.

## Configuration
- `SRAM_BRIDGE_MMIO_EN` defined:
  - Address `16'hFFFF` never touches the SRAM; `CE_N` stays high.
  - Reads return the synchronized `Switches` through the same state timing; `rdata` captures the switches in RD_CAP.
  - Writes load `HEX_Data <= MDR` in WR_HOLD.
- Not defined:
  - `16'hFFFF` is an ordinary SRAM word.
  - `HEX_Data` is tied to 0 and `Switches` is unused.

## Structure
- Package `lc3_mem_pkg` holds:
  - the state enum;
  - `IO_SW_HEX_ADDR = 16'hFFFF`;
  - `SRAM_ADDR_W = 20`;
  - the `WAIT_CYCLES` legal-range bounds.
- One sub-module, `switch_sync`: a two-flop synchronizer on `Switches`, reset to 0. It is instantiated only under `SRAM_BRIDGE_MMIO_EN`.

## Test plan
- Reset, then a `Mem_OE` 3-cycle burst at `MAR=16'h0030` with the SRAM model returning `16'h1234`: `Data_to_CPU=16'h1234` in the third strobe cycle, and `Mem_Ready` pulses at t+2.
- `Mem_WE` at `MAR=16'h0040`, `MDR=16'hBEEF`: `SRAM_WE_N` is low exactly 2 cycles, data is driven through WR_HOLD, and a later read returns `16'hBEEF`.
- Hold `Mem_OE` high for 10 cycles: exactly one access and one `Mem_Ready` pulse.
- Raise `Mem_OE` during WR_PULSE: `pending` is set, and the read starts the cycle after the write returns to IDLE.
- Deassert `Reset_n` in RD_ACCESS: next cycle is IDLE with all controls high, and no `Mem_Ready` pulse.
- With MMIO: `Switches=16'h00A5`, read `16'hFFFF` gives `Data_to_CPU=16'h00A5` and `CE_N` stays high; writing `16'h0C0D` gives `HEX_Data=16'h0C0D`.

Source files
------------

// File: rtl/lc3_mem_pkg.sv
// Shared types and constants for the LC-3 SRAM bridge.
package lc3_mem_pkg;

  localparam int unsigned SRAM_ADDR_W     = 20;
  localparam logic [15:0] IO_SW_HEX_ADDR  = 16'hFFFF;
  localparam int unsigned WAIT_CYCLES_MIN = 1;
  localparam int unsigned WAIT_CYCLES_MAX = 7;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RD_ACCESS = 3'd1,
    ST_RD_CAP    = 3'd2,
    ST_WR_PULSE  = 3'd3,
    ST_WR_HOLD   = 3'd4
  } bridge_state_e;

endpackage

// File: rtl/sram_bridge_switch_sync.sv
// Two-flop synchronizer bringing the raw board switches into the Clk domain.
module switch_sync
  import lc3_mem_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic [15:0] sw_in,
  output logic [15:0] sw_out
);

  logic [15:0] meta_q, meta_d;
  logic [15:0] sync_q, sync_d;

  // Shift the switches one stage per clock.
  always_comb begin
    meta_d = sw_in;
    sync_d = meta_q;
  end

  // Synchronizer flops, cleared by reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign sw_out = sync_q;

endmodule

// File: rtl/sram_bridge.sv
// Fixed-latency bridge between the LC-3 ISDU memory strobes and a 16-bit async SRAM.
// Optional memory-mapped switch/hex word at 16'hFFFF when SRAM_BRIDGE_MMIO_EN is defined.
module sram_bridge
  import lc3_mem_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
)
(
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   Mem_OE,
  input  logic                   Mem_WE,
  input  logic [15:0]            MAR,
  input  logic [15:0]            MDR,
  input  logic [15:0]            Switches,
  input  logic [15:0]            SRAM_DQ_in,
  output logic [15:0]            Data_to_CPU,
  output logic                   Mem_Ready,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic [15:0]            SRAM_DQ_out,
  output logic                   SRAM_DQ_oe,
  output logic [15:0]            HEX_Data
);

  // Out-of-range settings are clamped into the 3-bit counter's legal window.
  localparam int unsigned WAIT_EFF =
    (WAIT_CYCLES < WAIT_CYCLES_MIN) ? WAIT_CYCLES_MIN :
    (WAIT_CYCLES > WAIT_CYCLES_MAX) ? WAIT_CYCLES_MAX : WAIT_CYCLES;
  localparam logic [2:0] RD_LOAD = 3'(WAIT_EFF - 1);
  localparam logic [2:0] WR_LOAD = 3'(WAIT_EFF);

  bridge_state_e state_q, state_d;
  logic [2:0]    wait_q, wait_d;
  logic          req_q, req_d;
  logic          pending_q, pending_d;
  logic          pend_wr_q, pend_wr_d;
  logic          pend_io_q, pend_io_d;
  logic [15:0]   pend_addr_q, pend_addr_d;
  logic [15:0]   pend_data_q, pend_data_d;
  logic          io_q, io_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [15:0]   hex_q, hex_d;

  logic          req;
  logic          req_rise;
  logic          is_io;
  logic [15:0]   sw_sync;
  logic [15:0]   rd_src;

`ifdef SRAM_BRIDGE_MMIO_EN
  switch_sync u_switch_sync (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .sw_in   (Switches),
    .sw_out  (sw_sync)
  );
  assign is_io = (MAR == IO_SW_HEX_ADDR);
`else
  logic unused_switches;
  assign unused_switches = ^Switches;
  assign sw_sync = '0;
  assign is_io   = 1'b0;
`endif

  assign req      = Mem_OE | Mem_WE;
  assign req_rise = req & ~req_q;
  assign rd_src   = io_q ? sw_sync : SRAM_DQ_in;

  // Next-state: accept/queue requests, sequence timed states, capture results.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    req_d       = req;
    pending_d   = pending_q;
    pend_wr_d   = pend_wr_q;
    pend_io_d   = pend_io_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    io_d        = io_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    hex_d       = hex_q;

    unique case (state_q)
      ST_IDLE: begin
        // A queued request wins; any fresh edge in this cycle is dropped.
        if (pending_q) begin
          pending_d = 1'b0;
          addr_d    = pend_addr_q;
          wdata_d   = pend_data_q;
          io_d      = pend_io_q;
          state_d   = pend_wr_q ? ST_WR_PULSE : ST_RD_ACCESS;
          wait_d    = pend_wr_q ? WR_LOAD : RD_LOAD;
        end else if (req_rise) begin
          addr_d  = MAR;
          wdata_d = MDR;
          io_d    = is_io;
          state_d = Mem_WE ? ST_WR_PULSE : ST_RD_ACCESS;
          wait_d  = Mem_WE ? WR_LOAD : RD_LOAD;
        end
      end
      ST_RD_ACCESS: begin
        if (wait_q == '0) state_d = ST_RD_CAP;
        else              wait_d  = wait_q - 3'd1;
      end
      ST_RD_CAP: begin
        rdata_d = rd_src;
        state_d = ST_IDLE;
      end
      ST_WR_PULSE: begin
        if (wait_q == '0) state_d = ST_WR_HOLD;
        else              wait_d  = wait_q - 3'd1;
      end
      ST_WR_HOLD: begin
`ifdef SRAM_BRIDGE_MMIO_EN
        if (io_q) hex_d = wdata_q;
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Edges arriving mid-access are queued once; later ones are lost.
    if (state_q != ST_IDLE && req_rise && !pending_q) begin
      pending_d   = 1'b1;
      pend_wr_d   = Mem_WE;
      pend_io_d   = is_io;
      pend_addr_d = MAR;
      pend_data_d = MDR;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      wait_q      <= '0;
      req_q       <= 1'b0;
      pending_q   <= 1'b0;
      pend_wr_q   <= 1'b0;
      pend_io_q   <= 1'b0;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      io_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      hex_q       <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      req_q       <= req_d;
      pending_q   <= pending_d;
      pend_wr_q   <= pend_wr_d;
      pend_io_q   <= pend_io_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      io_q        <= io_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      hex_q       <= hex_d;
    end
  end

  // SRAM strobes, completion pulse and CPU read mux decoded from the state.
  always_comb begin
    SRAM_CE_N   = 1'b1;
    SRAM_OE_N   = 1'b1;
    SRAM_WE_N   = 1'b1;
    SRAM_UB_N   = 1'b1;
    SRAM_LB_N   = 1'b1;
    SRAM_DQ_oe  = 1'b0;
    Mem_Ready   = 1'b0;
    Data_to_CPU = rdata_q;

    unique case (state_q)
      ST_RD_ACCESS, ST_RD_CAP: begin
        Data_to_CPU = rd_src;
        Mem_Ready   = (state_q == ST_RD_CAP);
        if (!io_q) begin
          SRAM_CE_N = 1'b0;
          SRAM_OE_N = 1'b0;
          SRAM_UB_N = 1'b0;
          SRAM_LB_N = 1'b0;
        end
      end
      ST_WR_PULSE: begin
        if (!io_q) begin
          SRAM_CE_N  = 1'b0;
          SRAM_WE_N  = 1'b0;
          SRAM_UB_N  = 1'b0;
          SRAM_LB_N  = 1'b0;
          SRAM_DQ_oe = 1'b1;
        end
      end
      ST_WR_HOLD: begin
        Mem_Ready = 1'b1;
        if (!io_q) begin
          SRAM_CE_N  = 1'b0;
          SRAM_UB_N  = 1'b0;
          SRAM_LB_N  = 1'b0;
          SRAM_DQ_oe = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign SRAM_ADDR   = {{(SRAM_ADDR_W-16){1'b0}}, addr_q};
  assign SRAM_DQ_out = wdata_q;
  assign HEX_Data    = hex_q;

endmodule
